temp_spram_scheduler: RTL and testbench
=======================================

Name: temp_spram_scheduler

Overview:
- Sequences temperature-sensor bytes into the single-port SPRAM and shares that port with a readout requester (the MCU readout path).
- Pairs two incoming bytes (MSB first, then LSB) into one 16-bit sample and commits it at an auto-incrementing circular address.
- Interleaves single-word reads between writes.
- Sits between the sensor byte interface and the SB_SPRAM256KA instance.

Parameters:
- ADDR_W, 14, SPRAM word-address width.
- DEPTH, 16384, number of words in the buffer; must be <= 2**ADDR_W.
- WRAP, 1, 1 = overwrite oldest when full; 0 = stop writing when full.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of pointer, count, byte phase, pending flags and overrun.
- temp_valid  input  1  one-cycle strobe: temp_byte is valid this cycle.
- temp_byte  input  8  sensor byte; the first byte of a pair is the MSB, the second is the LSB.
- rd_req  input  1  one-cycle read request pulse.
- rd_addr  input  ADDR_W  read word address, captured with rd_req.
- rd_data  output  16  read data; valid only while rd_valid is high.
- rd_valid  output  1  one-cycle pulse marking rd_data.
- spram_addr  output  ADDR_W  SPRAM address.
- spram_wdata  output  16  SPRAM write data.
- spram_we  output  1  SPRAM write enable.
- spram_maskwe  output  4  4'b1111 when spram_we is high, else 4'b0000.
- spram_rdata  input  16  SPRAM read data; valid the cycle after the address is presented.
- wr_ptr  output  ADDR_W  next write address.
- count  output  ADDR_W+1  number of valid words held.
- full  output  1  high when count == DEPTH.
- overrun  output  1  sticky: a sample was dropped.

Behaviour:
- Reset (reset low, asynchronous): byte phase=MSB; wr_pend=0; rd_pend=0; port FSM=P_IDLE; wr_ptr=0; count=0; overrun=0; all SPRAM outputs 0; rd_valid=0; rd_data=0.
- clear has the same effect as reset, but synchronously. While clear is high, temp_valid and rd_req are ignored.
- Byte assembly (independent of the port FSM):
  - MSB phase + temp_valid: msb_reg<=temp_byte; phase->LSB.
  - LSB phase + temp_valid: word={msb_reg,temp_byte}; phase->MSB.
  - If wr_pend==0 and the word is allowed by the full rule: wr_word<=word, wr_pend<=1.
  - Otherwise the word is dropped and overrun<=1.
- Full rule:
  - WRAP=1: never blocks.
  - WRAP=0: when full==1, completed words are dropped and overrun is set.
- Read capture: rd_req with rd_pend==0 sets rd_pend=1 and latches rd_addr. rd_req while rd_pend==1 or the FSM is in a read state is ignored; it does not set overrun.
- Port FSM (Moore; SPRAM outputs decoded from state plus registers):
  - P_IDLE: if wr_pend -> P_WRITE; else if rd_pend -> P_RD_ISSUE. Writes have priority.
  - P_WRITE (1 cycle): spram_we=1, spram_maskwe=1111, spram_addr=wr_ptr, spram_wdata=wr_word.
    - At the end of the cycle: wr_pend<=0; wr_ptr<=wr_ptr+1 (DEPTH-1 wraps to 0); count<=count+1 saturating at DEPTH.
    - Next state -> P_IDLE.
  - P_RD_ISSUE (1 cycle): spram_we=0, spram_addr=latched rd_addr; rd_pend<=0; next state -> P_RD_DATA.
  - P_RD_DATA (1 cycle): rd_valid=1, rd_data=spram_rdata; next state -> P_IDLE.
  - Default and unreachable encodings -> P_IDLE.
- Latency:
  - LSB accepted in cycle t -> wr_pend high in t+1 -> spram_we high in t+2 (when the FSM is idle).
  - rd_req in cycle t -> P_RD_ISSUE in t+2 -> rd_valid in t+3 (no write pending).
  - A pending write delays a read by exactly 2 cycles (P_WRITE plus the return to P_IDLE).
  - Worst-case delay before a pending write commits: 3 cycles (a read just issued).
- Simultaneous events:
  - LSB completion in the same cycle as P_WRITE clears wr_pend: the new word is dropped (wr_pend was still 1) and overrun is set. Sources must space sample pairs at least 4 cycles apart.
  - rd_req and temp_valid in the same cycle are both captured.
- Reset asserted mid-operation aborts any write or read; no rd_valid is produced.
- spram_addr, spram_wdata and rd_data read as 0 in P_IDLE.

Test Plan:
- Reset then bytes 8'h12, 8'h34 on consecutive cycles -> two cycles later spram_we=1, addr=0, wdata=16'h1234, maskwe=1111; afterwards wr_ptr=1, count=1.
- rd_req with rd_addr=0 in an idle cycle, spram_rdata model returning 16'h1234 -> rd_valid one-cycle pulse exactly 3 cycles after rd_req, with rd_data=16'h1234.
- Same cycle: LSB completes and rd_req -> write occurs first, then the read; rd_valid arrives at latency 5 and carries the newly written data if the addresses match.
- DEPTH=4, WRAP=1: write 6 words -> wr_ptr sequence 0,1,2,3,0,1; count saturates at 4; full=1; overrun=0.
- DEPTH=4, WRAP=0: write 5 words -> the 5th is not written (no spram_we); overrun=1; count=4; clear -> count=0, overrun=0, wr_ptr=0.
- Pair completes while the previous word is blocked behind P_RD_ISSUE -> second word dropped, overrun=1; reset asserted during P_RD_ISSUE -> no rd_valid, all outputs return to reset values immediately.

Source files
------------

// File: rtl/temp_spram_scheduler.sv
// -----------------------------------------------------------------------------
// temp_spram_scheduler
//
// Packs temperature-sensor bytes (MSB first, then LSB) into 16-bit samples and
// writes them into a single-port SPRAM at a circular, auto-incrementing
// address. The same SPRAM port is shared with a single-word readout path; a
// small Moore FSM arbitrates the port, with writes taking priority over reads.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          asynchronous active-low reset
//   clear          synchronous clear (same effect as reset)
//   temp_valid     strobe: temp_byte is valid this cycle
//   temp_byte      sensor byte (first of a pair = MSB, second = LSB)
//   rd_req         single-cycle read request, captures rd_addr
//   rd_addr        word address to read
//   rd_data        read data, qualified by rd_valid (0 otherwise)
//   rd_valid       single-cycle pulse marking rd_data
//   spram_addr     SPRAM word address
//   spram_wdata    SPRAM write data
//   spram_we       SPRAM write enable
//   spram_maskwe   SPRAM nibble write mask (all ones while writing)
//   spram_rdata    SPRAM read data, valid the cycle after the address
//   wr_ptr         next write address
//   count          number of valid words held (saturates at DEPTH)
//   full           count == DEPTH
//   overrun        sticky: a completed sample was dropped
// -----------------------------------------------------------------------------
module temp_spram_scheduler #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384,
    parameter bit WRAP   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              temp_valid,
    input  logic [7:0]        temp_byte,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] spram_addr,
    output logic [15:0]       spram_wdata,
    output logic              spram_we,
    output logic [3:0]        spram_maskwe,
    input  logic [15:0]       spram_rdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overrun
);

    typedef enum logic [1:0] {
        P_IDLE     = 2'd0,
        P_WRITE    = 2'd1,
        P_RD_ISSUE = 2'd2,
        P_RD_DATA  = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    // byte phase: 0 = expecting MSB, 1 = expecting LSB
    logic              phase_q,   phase_d;
    logic [7:0]        msb_q,     msb_d;
    logic              wr_pend_q, wr_pend_d;
    logic [15:0]       wr_word_q, wr_word_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_W:0]   count_q,   count_d;
    logic              overrun_q, overrun_d;
    state_e            state_q,   state_d;

    logic              sp_we_q,    sp_we_d;
    logic [ADDR_W-1:0] sp_addr_q,  sp_addr_d;
    logic [15:0]       sp_wdata_q, sp_wdata_d;
    logic              rd_valid_q, rd_valid_d;

    logic              full_s;
    logic              rd_busy_s;

    assign full_s    = (count_q == DEPTH_CNT);
    assign rd_busy_s = (state_q == P_RD_ISSUE) || (state_q == P_RD_DATA);

    // Next-state logic: port FSM, byte assembly, read capture and clear
    always_comb begin
        phase_d   = phase_q;
        msb_d     = msb_q;
        wr_pend_d = wr_pend_q;
        wr_word_d = wr_word_q;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        state_d   = P_IDLE;

        if (clear) begin
            phase_d   = 1'b0;
            msb_d     = 8'h00;
            wr_pend_d = 1'b0;
            wr_word_d = 16'h0000;
            rd_pend_d = 1'b0;
            rd_addr_d = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            overrun_d = 1'b0;
            state_d   = P_IDLE;
        end else begin
            case (state_q)
                P_IDLE: begin
                    if (wr_pend_q) begin
                        state_d = P_WRITE;
                    end else if (rd_pend_q) begin
                        state_d = P_RD_ISSUE;
                    end else begin
                        state_d = P_IDLE;
                    end
                end
                P_WRITE: begin
                    wr_pend_d = 1'b0;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                    if (count_q != DEPTH_CNT) begin
                        count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
                    end else begin
                        count_d = count_q;
                    end
                    state_d = P_IDLE;
                end
                P_RD_ISSUE: begin
                    rd_pend_d = 1'b0;
                    state_d   = P_RD_DATA;
                end
                P_RD_DATA: begin
                    state_d = P_IDLE;
                end
                default: begin
                    state_d = P_IDLE;
                end
            endcase

            // A word completing while the previous one is still pending
            // (including the P_WRITE cycle itself) is lost.
            if (temp_valid) begin
                if (!phase_q) begin
                    msb_d   = temp_byte;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!wr_pend_q && !((WRAP == 1'b0) && full_s)) begin
                        wr_word_d = {msb_q, temp_byte};
                        wr_pend_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end else begin
                phase_d = phase_q;
            end

            if (rd_req && !rd_pend_q && !rd_busy_s) begin
                rd_pend_d = 1'b1;
                rd_addr_d = rd_addr;
            end else begin
                rd_addr_d = rd_addr_q;
            end
        end
    end

    // Output decode from the next state so the SPRAM-facing pins are registered
    always_comb begin
        sp_we_d    = 1'b0;
        sp_addr_d  = '0;
        sp_wdata_d = 16'h0000;
        rd_valid_d = 1'b0;
        case (state_d)
            P_WRITE: begin
                sp_we_d    = 1'b1;
                sp_addr_d  = wr_ptr_d;
                sp_wdata_d = wr_word_d;
            end
            P_RD_ISSUE: begin
                sp_addr_d = rd_addr_d;
            end
            P_RD_DATA: begin
                rd_valid_d = 1'b1;
            end
            P_IDLE: begin
                sp_we_d = 1'b0;
            end
            default: begin
                sp_we_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= 1'b0;
            msb_q      <= 8'h00;
            wr_pend_q  <= 1'b0;
            wr_word_q  <= 16'h0000;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            state_q    <= P_IDLE;
            sp_we_q    <= 1'b0;
            sp_addr_q  <= '0;
            sp_wdata_q <= 16'h0000;
            rd_valid_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            msb_q      <= msb_d;
            wr_pend_q  <= wr_pend_d;
            wr_word_q  <= wr_word_d;
            rd_pend_q  <= rd_pend_d;
            rd_addr_q  <= rd_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            state_q    <= state_d;
            sp_we_q    <= sp_we_d;
            sp_addr_q  <= sp_addr_d;
            sp_wdata_q <= sp_wdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // SPRAM data arrives the cycle after the address, so rd_data is a gated
    // pass-through during P_RD_DATA rather than a register.
    assign rd_data      = rd_valid_q ? spram_rdata : 16'h0000;
    assign rd_valid     = rd_valid_q;
    assign spram_addr   = sp_addr_q;
    assign spram_wdata  = sp_wdata_q;
    assign spram_we     = sp_we_q;
    assign spram_maskwe = sp_we_q ? 4'b1111 : 4'b0000;
    assign wr_ptr       = wr_ptr_q;
    assign count        = count_q;
    assign full         = full_s;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_temp_spram_scheduler.sv
// -----------------------------------------------------------------------------
// Directed bench for temp_spram_scheduler. Instance A uses default parameters
// with a small SPRAM model; instances B (DEPTH=4, WRAP=1) and C (DEPTH=4,
// WRAP=0) share the same stimulus for the buffer-depth cases.
// -----------------------------------------------------------------------------
module tb_temp_spram_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        temp_valid = 1'b0;
    logic [7:0]  temp_byte = 8'h00;
    logic        rd_req = 1'b0;
    logic [13:0] rd_addr = 14'd0;
    logic [15:0] spram_rdata;

    logic [15:0] a_rd_data, b_rd_data, c_rd_data;
    logic        a_rd_valid, b_rd_valid, c_rd_valid;
    logic [13:0] a_addr, b_addr, c_addr;
    logic [15:0] a_wdata, b_wdata, c_wdata;
    logic        a_we, b_we, c_we;
    logic [3:0]  a_mask, b_mask, c_mask;
    logic [13:0] a_wr_ptr, b_wr_ptr, c_wr_ptr;
    logic [14:0] a_count, b_count, c_count;
    logic        a_full, b_full, c_full;
    logic        a_overrun, b_overrun, c_overrun;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:15];

    always #5 clk = ~clk;

    temp_spram_scheduler u_a (
        .clk(clk), .reset(reset), .clear(clear), .temp_valid(temp_valid),
        .temp_byte(temp_byte), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .spram_addr(a_addr),
        .spram_wdata(a_wdata), .spram_we(a_we), .spram_maskwe(a_mask),
        .spram_rdata(spram_rdata), .wr_ptr(a_wr_ptr), .count(a_count),
        .full(a_full), .overrun(a_overrun)
    );

    temp_spram_scheduler #(.ADDR_W(14), .DEPTH(4), .WRAP(1'b1)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .temp_valid(temp_valid),
        .temp_byte(temp_byte), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .spram_addr(b_addr),
        .spram_wdata(b_wdata), .spram_we(b_we), .spram_maskwe(b_mask),
        .spram_rdata(spram_rdata), .wr_ptr(b_wr_ptr), .count(b_count),
        .full(b_full), .overrun(b_overrun)
    );

    temp_spram_scheduler #(.ADDR_W(14), .DEPTH(4), .WRAP(1'b0)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .temp_valid(temp_valid),
        .temp_byte(temp_byte), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(c_rd_data), .rd_valid(c_rd_valid), .spram_addr(c_addr),
        .spram_wdata(c_wdata), .spram_we(c_we), .spram_maskwe(c_mask),
        .spram_rdata(spram_rdata), .wr_ptr(c_wr_ptr), .count(c_count),
        .full(c_full), .overrun(c_overrun)
    );

    // Synchronous-read SPRAM model attached to instance A
    always @(posedge clk) begin
        if (a_we) begin
            mem[a_addr[3:0]] <= a_wdata;
        end
        spram_rdata <= mem[a_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present MSB then LSB on consecutive edges; returns one cycle after the LSB edge
    task automatic send_pair(input logic [7:0] m, input logic [7:0] l);
        temp_valid = 1'b1;
        temp_byte  = m;
        tick();
        temp_byte  = l;
        tick();
        temp_valid = 1'b0;
    endtask

    logic [13:0] exp_addr [0:5];
    logic [14:0] exp_cnt  [0:5];

    initial begin
        exp_addr[0] = 14'd0; exp_addr[1] = 14'd1; exp_addr[2] = 14'd2;
        exp_addr[3] = 14'd3; exp_addr[4] = 14'd0; exp_addr[5] = 14'd1;
        exp_cnt[0]  = 15'd1; exp_cnt[1]  = 15'd2; exp_cnt[2]  = 15'd3;
        exp_cnt[3]  = 15'd4; exp_cnt[4]  = 15'd4; exp_cnt[5]  = 15'd4;

        // ---- reset state ----
        #2;
        chk("rst_we",      32'(a_we),      32'd0);
        chk("rst_addr",    32'(a_addr),    32'd0);
        chk("rst_rd_data", 32'(a_rd_data), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_count",   32'(a_count),   32'd0);
        chk("rst_wr_ptr",  32'(a_wr_ptr),  32'd0);
        chk("rst_overrun", 32'(a_overrun), 32'd0);
        chk("rst_mask",    32'(a_mask),    32'd0);

        // ---- first sample: 12 34 -> write at addr 0 two cycles after LSB ----
        send_pair(8'h12, 8'h34);
        chk("w1_pre_we", 32'(a_we), 32'd0);
        tick();
        chk("w1_we",    32'(a_we),    32'd1);
        chk("w1_addr",  32'(a_addr),  32'd0);
        chk("w1_wdata", 32'(a_wdata), 32'h1234);
        chk("w1_mask",  32'(a_mask),  32'hf);
        tick();
        chk("w1_we_off", 32'(a_we),     32'd0);
        chk("w1_ptr",    32'(a_wr_ptr), 32'd1);
        chk("w1_count",  32'(a_count),  32'd1);

        // ---- read of addr 0: rd_valid 3 cycles after rd_req ----
        rd_req  = 1'b1;
        rd_addr = 14'd0;
        tick();
        rd_req  = 1'b0;
        chk("r1_valid_t1", 32'(a_rd_valid), 32'd0);
        tick();
        chk("r1_issue_addr", 32'(a_addr),     32'd0);
        chk("r1_issue_we",   32'(a_we),       32'd0);
        chk("r1_valid_t2",   32'(a_rd_valid), 32'd0);
        tick();
        chk("r1_valid", 32'(a_rd_valid), 32'd1);
        chk("r1_data",  32'(a_rd_data),  32'h1234);
        tick();
        chk("r1_valid_off", 32'(a_rd_valid), 32'd0);
        chk("r1_data_idle", 32'(a_rd_data),  32'd0);

        // ---- LSB and rd_req together: write first, read at latency 5 ----
        temp_valid = 1'b1;
        temp_byte  = 8'hAB;
        tick();
        temp_byte  = 8'hCD;
        rd_req     = 1'b1;
        rd_addr    = 14'd1;
        tick();
        temp_valid = 1'b0;
        rd_req     = 1'b0;
        tick();
        chk("s_we",    32'(a_we),    32'd1);
        chk("s_addr",  32'(a_addr),  32'd1);
        chk("s_wdata", 32'(a_wdata), 32'hABCD);
        tick();
        chk("s_valid_t3", 32'(a_rd_valid), 32'd0);
        tick();
        chk("s_issue_addr", 32'(a_addr),     32'd1);
        chk("s_valid_t4",   32'(a_rd_valid), 32'd0);
        tick();
        chk("s_valid", 32'(a_rd_valid), 32'd1);
        chk("s_data",  32'(a_rd_data),  32'hABCD);
        tick();
        chk("s_ptr",   32'(a_wr_ptr), 32'd2);
        chk("s_count", 32'(a_count),  32'd2);

        // ---- word blocked behind a read, next pair dropped ----
        rd_req     = 1'b1;
        rd_addr    = 14'd0;
        temp_valid = 1'b1;
        temp_byte  = 8'h55;
        tick();
        rd_req     = 1'b0;
        temp_byte  = 8'h66;
        tick();
        chk("b_issue_we", 32'(a_we), 32'd0);
        temp_byte  = 8'h77;
        tick();
        chk("b_rd_valid", 32'(a_rd_valid), 32'd1);
        chk("b_rd_data",  32'(a_rd_data),  32'h1234);
        temp_byte  = 8'h88;
        tick();
        temp_valid = 1'b0;
        chk("b_overrun", 32'(a_overrun), 32'd1);
        tick();
        chk("b_we",    32'(a_we),    32'd1);
        chk("b_addr",  32'(a_addr),  32'd2);
        chk("b_wdata", 32'(a_wdata), 32'h5566);
        tick();
        chk("b_count", 32'(a_count), 32'd3);
        tick();
        chk("b_no_second_we", 32'(a_we), 32'd0);

        // ---- reset asserted during P_RD_ISSUE ----
        rd_req  = 1'b1;
        rd_addr = 14'd5;
        tick();
        rd_req  = 1'b0;
        tick();
        chk("ra_issue_addr", 32'(a_addr), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("ra_addr",    32'(a_addr),     32'd0);
        chk("ra_ptr",     32'(a_wr_ptr),   32'd0);
        chk("ra_count",   32'(a_count),    32'd0);
        chk("ra_overrun", 32'(a_overrun),  32'd0);
        chk("ra_valid",   32'(a_rd_valid), 32'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ra_no_valid", 32'(a_rd_valid), 32'd0);
            chk("ra_no_we",    32'(a_we),       32'd0);
        end

        // ---- DEPTH=4: WRAP=1 (B) vs WRAP=0 (C), six samples ----
        for (int i = 0; i < 6; i++) begin
            send_pair(8'h10 + 8'(i), 8'h20 + 8'(i));
            tick();
            chk("d_b_we",    32'(b_we),    32'd1);
            chk("d_b_addr",  32'(b_addr),  32'(exp_addr[i]));
            chk("d_b_wdata", 32'(b_wdata), {16'h0000, 8'h10 + 8'(i), 8'h20 + 8'(i)});
            if (i < 4) begin
                chk("d_c_we",   32'(c_we),   32'd1);
                chk("d_c_addr", 32'(c_addr), 32'(exp_addr[i]));
            end else begin
                chk("d_c_we_blocked", 32'(c_we), 32'd0);
            end
            tick();
            chk("d_b_count", 32'(b_count), 32'(exp_cnt[i]));
            if (i == 4) begin
                chk("d_c_overrun", 32'(c_overrun), 32'd1);
                chk("d_c_count",   32'(c_count),   32'd4);
                chk("d_c_full",    32'(c_full),    32'd1);
            end
            tick();
        end
        chk("d_b_full",    32'(b_full),    32'd1);
        chk("d_b_overrun", 32'(b_overrun), 32'd0);
        chk("d_b_ptr",     32'(b_wr_ptr),  32'd2);

        // ---- synchronous clear ----
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("c_count",   32'(c_count),   32'd0);
        chk("c_overrun", 32'(c_overrun), 32'd0);
        chk("c_ptr",     32'(c_wr_ptr),  32'd0);
        chk("c_full",    32'(c_full),    32'd0);
        chk("c_b_ptr",   32'(b_wr_ptr),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
